// File: rtl/prince_sbox_cms_compress_if.sv
// Handshake bundle between the CMS component functions, the compression stage and its consumer.
// PRINCE_CMS_REFRESH_EN adds the in_rand mask nibble.
interface prince_sbox_cms_compress_if #(
  parameter int NFUNC = 4,
  parameter int NSH   = 2
) ();
  logic [4*NFUNC-1:0] in_comp;
  logic               in_valid;
  logic               in_ready;
  logic [4*NSH-1:0]   out_share;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
`ifdef PRINCE_CMS_REFRESH_EN
  logic [3:0]         in_rand;
`endif

  modport slave (
    input  in_comp, in_valid, out_ready,
`ifdef PRINCE_CMS_REFRESH_EN
    input  in_rand,
`endif
    output in_ready, out_share, out_valid, out_last
  );

  modport master (
    output in_comp, in_valid, out_ready,
`ifdef PRINCE_CMS_REFRESH_EN
    output in_rand,
`endif
    input  in_ready, out_share, out_valid, out_last
  );
endinterface

// File: rtl/prince_sbox_cms_compress.sv
// PRINCE S-box CMS compression: glitch-barrier register, XOR share compression, nibble counter.
// Optional mask refresh of shares 0 and NSH-1 when PRINCE_CMS_REFRESH_EN is defined.
module prince_sbox_cms_compress #(
  parameter int NFUNC = 4,
  parameter int NSH   = 2,
  parameter int NNIB  = 16
) (
  input logic                    clk,
  input logic                    rst,
  prince_sbox_cms_compress_if.slave bus
);
  localparam int CW = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(NNIB - 1);

  generate
    if ((NFUNC % NSH) != 0) begin : g_bad_param
      $error("NFUNC must be a multiple of NSH");
    end
  endgenerate

  logic [4*NFUNC-1:0] s1_comp_reg;
  logic               s1_v_reg;
`ifdef PRINCE_CMS_REFRESH_EN
  logic [3:0]         s1_rand_reg;
`endif
  logic [4*NSH-1:0]   share_reg;
  logic [4*NSH-1:0]   share_next;
  logic               s2_v_reg;
  logic [CW-1:0]      cnt_reg;

  logic s2_adv;
  logic in_xfer;
  logic out_xfer;

  assign s2_adv       = !s2_v_reg || bus.out_ready;
  assign bus.in_ready = !s1_v_reg || s2_adv;
  assign in_xfer      = bus.in_valid && bus.in_ready;
  assign out_xfer     = s2_v_reg && bus.out_ready;

  // Share s collects every component function f with f mod NSH == s.
  genvar gi;
  generate
    for (gi = 0; gi < NSH; gi++) begin : g_share
      logic [3:0] acc;
      always_comb begin
        acc = 4'h0;
        for (int f = gi; f < NFUNC; f += NSH) begin
          acc = acc ^ s1_comp_reg[4*f +: 4];
        end
`ifdef PRINCE_CMS_REFRESH_EN
        if (gi == 0 || gi == NSH - 1) begin
          acc = acc ^ s1_rand_reg;
        end
`endif
      end
      assign share_next[4*gi +: 4] = acc;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_comp_reg <= '0;
      s1_v_reg    <= 1'b0;
`ifdef PRINCE_CMS_REFRESH_EN
      s1_rand_reg <= 4'h0;
`endif
      share_reg   <= '0;
      s2_v_reg    <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      // Raw components land here untouched; no logic may precede this register.
      if (in_xfer) begin
        s1_comp_reg <= bus.in_comp;
`ifdef PRINCE_CMS_REFRESH_EN
        s1_rand_reg <= bus.in_rand;
`endif
        s1_v_reg    <= 1'b1;
      end else if (s1_v_reg && s2_adv) begin
        s1_v_reg    <= 1'b0;
      end

      if (s2_adv) begin
        s2_v_reg <= s1_v_reg;
        if (s1_v_reg) begin
          share_reg <= share_next;
        end
      end

      if (out_xfer) begin
        cnt_reg <= (cnt_reg == CNT_MAX) ? '0 : cnt_reg + 1'b1;
      end
    end
  end

  assign bus.out_share = share_reg;
  assign bus.out_valid = s2_v_reg;
  assign bus.out_last  = s2_v_reg && (cnt_reg == CNT_MAX);
endmodule

// File: tb/tb_prince_sbox_cms_compress.sv
// Bench for prince_sbox_cms_compress: directed vectors, streaming/stall/reset sequences and a
// randomized run scored against a queue-based reference model. Honours PRINCE_CMS_REFRESH_EN.
module tb_prince_sbox_cms_compress;
  localparam int NFUNC = 4;
  localparam int NSH   = 2;
  localparam int NNIB  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prince_sbox_cms_compress_if #(.NFUNC(NFUNC), .NSH(NSH)) bus ();

  prince_sbox_cms_compress #(.NFUNC(NFUNC), .NSH(NSH), .NNIB(NNIB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: share s = XOR of components f with f mod NSH == s, optional refresh mask.
  function automatic logic [4*NSH-1:0] ref_share(input logic [4*NFUNC-1:0] comp, input logic [3:0] r);
    logic [3:0] sh [NSH];
    logic [4*NSH-1:0] res;
    for (int s = 0; s < NSH; s++) sh[s] = 4'h0;
    for (int f = 0; f < NFUNC; f++) sh[f % NSH] = sh[f % NSH] ^ comp[4*f +: 4];
`ifdef PRINCE_CMS_REFRESH_EN
    sh[0] = sh[0] ^ r;
    if (NSH > 1) sh[NSH-1] = sh[NSH-1] ^ r;
`else
    if (r != 4'h0) sh[0] = sh[0];
`endif
    for (int s = 0; s < NSH; s++) res[4*s +: 4] = sh[s];
    return res;
  endfunction

  function automatic logic [3:0] cur_rand();
`ifdef PRINCE_CMS_REFRESH_EN
    return bus.in_rand;
`else
    return 4'h0;
`endif
  endfunction

  task automatic set_rand(input logic [3:0] r);
`ifdef PRINCE_CMS_REFRESH_EN
    bus.in_rand = r;
`else
    if (r == 4'hx) $display("unused");
`endif
  endtask

  // Scoreboard: expected shares in acceptance order, plus output index modulo NNIB.
  logic [4*NSH-1:0] expq [$];
  int               out_idx = 0;
  logic             stall_prev = 1'b0;
  logic [4*NSH-1:0] prev_share;
  logic             prev_last;

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      out_idx    = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall out_valid", bus.out_valid, 1);
        check("stall out_share", bus.out_share, prev_share);
        check("stall out_last", bus.out_last, prev_last);
      end
      if (!bus.out_valid) check("idle out_last", bus.out_last, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious output: got share %h with no pending input", bus.out_share);
        end else begin
          check("out_share order", bus.out_share, expq.pop_front());
          check("out_last", bus.out_last, out_idx == NNIB - 1);
          out_idx = (out_idx + 1) % NNIB;
        end
      end
      if (bus.in_valid && bus.in_ready) expq.push_back(ref_share(bus.in_comp, cur_rand()));
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_share = bus.out_share;
      prev_last  = bus.out_last;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] comp;
    logic [3:0]  rnd;
    logic [7:0]  exp_plain;
    logic [7:0]  exp_ref;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_last", bus.out_last, 0);
    check("reset out_share", bus.out_share, 0);
    check("reset in_ready", bus.in_ready, 1);
    step();
    rst = 1'b0;
  endtask

  // Push n nibbles back-to-back with out_ready high; report where outputs and the last marker appeared.
  task automatic stream(input int n, output int outs, output int first_at, output int last_at, output int lasts);
    outs = 0; first_at = -1; last_at = -1; lasts = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < n + 4; i++) begin
      bus.in_valid = (i < n);
      bus.in_comp  = 16'($urandom);
      set_rand(4'($urandom));
      #1;
      if (i < n) check("load/drain in_ready", bus.in_ready, 1);
      if (bus.out_valid) begin
        if (first_at < 0) first_at = i;
        if (bus.out_last) begin
          lasts++;
          last_at = outs;
        end
        outs++;
      end
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int outs, first_at, last_at, lasts, acc;
    logic [7:0] exp;

    vecs[0] = '{16'h0F3C, 4'hA, 8'h33, 8'h99};
    vecs[1] = '{16'hFFFF, 4'h5, 8'h00, 8'h55};
    vecs[2] = '{16'h1234, 4'h0, 8'h26, 8'h26};
    vecs[3] = '{16'hA5C3, 4'hF, 8'h66, 8'h99};
    vecs[4] = '{16'h8001, 4'h1, 8'h81, 8'h90};
    vecs[5] = '{16'h0000, 4'h0, 8'h00, 8'h00};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_comp   = '0;
    bus.out_ready = 1'b0;
    set_rand(4'h0);
    do_reset();

    // Single-nibble vectors: one transfer, out_valid exactly two cycles later.
    for (int v = 0; v < 6; v++) begin
`ifdef PRINCE_CMS_REFRESH_EN
      exp = vecs[v].exp_ref;
`else
      exp = vecs[v].exp_plain;
`endif
      bus.in_valid  = 1'b1;
      bus.in_comp   = vecs[v].comp;
      set_rand(vecs[v].rnd);
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check("vec latency1 out_valid", bus.out_valid, 0);
      step();
      check("vec out_valid", bus.out_valid, 1);
      check("vec out_share", bus.out_share, exp);
      check("vec out_last", bus.out_last, 0);
      check("vec share xor", bus.out_share[3:0] ^ bus.out_share[7:4], vecs[v].exp_plain[3:0] ^ vecs[v].exp_plain[7:4]);
      step();
    end

    // Streaming 17 nibbles: first output 2 cycles in, last marker only on the 16th.
    do_reset();
    stream(17, outs, first_at, last_at, lasts);
    check("stream outputs", outs, 17);
    check("stream first latency", first_at, 2);
    check("stream last count", lasts, 1);
    check("stream last index", last_at, 15);

    // Back-pressure: both stages fill, in_ready drops, then everything drains in order.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_comp = 16'($urandom);
      set_rand(4'($urandom));
      step();
    end
    check("bp in_ready", bus.in_ready, 0);
    check("bp out_valid", bus.out_valid, 1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("bp drained", expq.size(), 0);
    check("bp idle", bus.out_valid, 0);

    // Reset after the 7th accepted nibble, then a fresh stream marks its 16th.
    do_reset();
    bus.out_ready = 1'b1;
    acc = 0;
    while (acc < 7) begin
      bus.in_valid = 1'b1;
      bus.in_comp  = 16'($urandom);
      #1;
      if (bus.in_ready) acc++;
      step();
    end
    do_reset();
    stream(16, outs, first_at, last_at, lasts);
    check("post-reset outputs", outs, 16);
    check("post-reset last index", last_at, 15);
    check("post-reset last count", lasts, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      bus.in_valid  = $urandom_range(0, 1);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_comp   = 16'($urandom);
      set_rand(4'($urandom));
      step();
    end
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("random drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
